// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FSM state encoding and the single-byte reflected update.
package crc32_pkg;

    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] XOROUT  = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CHECK   = 32'h2144_DF1C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bit-serial form of (crc >> 8) ^ T[(crc ^ b) & 8'hFF]; synthesis flattens it to the table XOR tree.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b,
                                             input logic [31:0] poly);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/crc32_step.sv
// Combinational fold of one beat into the CRC register, stopping at the first cleared keep bit.
module crc32_step
    import crc32_pkg::*;
#(
    parameter int          BYTES_PER_BEAT = 4,
    parameter logic [31:0] POLY           = 32'hEDB88320
) (
    input  logic [31:0]                 crc_in,
    input  logic [8*BYTES_PER_BEAT-1:0] data,
    input  logic [BYTES_PER_BEAT-1:0]   keep,
    output logic [31:0]                 crc_next,
    output logic                        keep_gap
);

    logic [31:0]               c;
    logic                      run;
    logic [BYTES_PER_BEAT-1:0] used;

    always_comb begin
        c    = crc_in;
        run  = 1'b1;
        used = '0;
        for (int i = 0; i < BYTES_PER_BEAT; i++) begin
            run     = run & keep[i];
            used[i] = run;
            if (run)
                c = crc_byte(c, data[8*i +: 8], POLY);
        end
        crc_next = c;
        // Any keep bit set beyond the first hole means the mask was not contiguous.
        keep_gap = |(keep & ~used);
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 with frame FSM and held result; CRC32_STREAM_CHECK_EN adds the FCS residue check on crc_ok.
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int          BYTES_PER_BEAT = 4,
    parameter logic [31:0] POLY           = 32'hEDB88320
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*BYTES_PER_BEAT-1:0] in_data,
    input  logic [BYTES_PER_BEAT-1:0]   in_keep,
    input  logic                        in_sof,
    input  logic                        in_eof,
    output logic                        crc_valid,
    input  logic                        crc_ready,
    output logic [31:0]                 crc_out,
    output logic                        crc_ok,
    output logic                        frame_err
);

    state_t                    state, state_nxt;
    logic [31:0]               crc_reg, crc_seed, crc_next;
    logic [BYTES_PER_BEAT-1:0] eff_keep;
    logic                      keep_gap, fire, orphan, take;

    assign fire     = in_valid && in_ready;
    assign orphan   = fire && (state == IDLE) && !in_sof;
    assign take     = fire && !orphan;
    assign crc_seed = in_sof ? INIT : crc_reg;
    assign eff_keep = in_eof ? in_keep : '1;

    crc32_step #(
        .BYTES_PER_BEAT(BYTES_PER_BEAT),
        .POLY          (POLY)
    ) u_step (
        .crc_in  (crc_seed),
        .data    (in_data),
        .keep    (eff_keep),
        .crc_next(crc_next),
        .keep_gap(keep_gap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACC: if (take) state_nxt = in_eof ? HOLD : ACC;
            HOLD:      if (crc_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state != HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_reg   <= INIT;
            crc_out   <= 32'h0;
            crc_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= orphan || (take && in_sof && state == ACC) || (take && in_eof && keep_gap);
            if (take)
                crc_reg <= crc_next;
            if (take && in_eof) begin
                crc_out   <= crc_next ^ XOROUT;
                crc_valid <= 1'b1;
            end else if (state == HOLD && crc_ready) begin
                crc_valid <= 1'b0;
            end
        end
    end

`ifdef CRC32_STREAM_CHECK_EN
    // A frame carrying its own FCS leaves the fixed residue, seen here after the output inversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                crc_ok <= 1'b0;
        else if (take && in_eof) crc_ok <= ((crc_next ^ XOROUT) == CHECK);
    end
`else
    assign crc_ok = 1'b0;
`endif

endmodule
